muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit: one shift-add or restoring-subtract step per cycle
// on operand magnitudes, with sign correction and register-file write-back on completion.
module muldiv_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              write_en
);

  // state | meaning
  // IDLE  | waiting for start; operands latched on acceptance
  // CALC  | one multiply/divide step per cycle, XLEN steps total
  // DONE  | one-cycle completion pulse, result/wr_addr valid

  localparam int               CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   opb;
  logic [ADDR_W-1:0] rd_q;

  logic            a_signed, b_signed, a_neg, b_neg, neg_in;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  // Remainder takes the dividend sign; everything else the XOR of operand signs.
  always_comb begin
    a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_signed = op[2] ? ~op[0] : ~op[1];
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    neg_in   = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = op[2] & (rs2_data == '0);
    div_ovf  = op[2] & ~op[0] & (rs1_data == SMIN) & (rs2_data == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = op[1] ? rs1_data : '1;
    else          fast_res = op[1] ? '0 : SMIN;
  end

  // Multiply: {acc,lo} is the product shifting right, lo starts as the multiplier.
  // Divide: acc is the partial remainder, lo shifts the dividend out and quotient bits in.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] acc_nxt, lo_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, opb & {XLEN{lo[0]}}};
    div_shift = {acc, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (op_q[2]) begin
      acc_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      acc_nxt = mul_sum[XLEN:1];
      lo_nxt  = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_raw, final_res;

  always_comb begin
    prod     = {acc_nxt, lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    div_raw  = op_q[1] ? acc_nxt : lo_nxt;
    if (op_q[2])                final_res = neg_q ? -div_raw : div_raw;
    else if (op_q[1:0] == 2'b00) final_res = prod_fix[XLEN-1:0];
    else                        final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      write_en <= 1'b0;
      result   <= '0;
      wr_addr  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opb      <= '0;
      rd_q     <= '0;
    end else begin
      done     <= 1'b0;
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            neg_q <= neg_in;
            acc   <= '0;
            lo    <= a_mag;
            opb   <= b_mag;
            rd_q  <= rd_addr;
            cnt   <= '0;
            busy  <= 1'b1;
            if (fast) begin
              state    <= DONE;
              done     <= 1'b1;
              write_en <= (rd_addr != '0);
              result   <= fast_res;
              wr_addr  <= rd_addr;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state    <= DONE;
            done     <= 1'b1;
            write_en <= (rd_q != '0);
            result   <= final_res;
            wr_addr  <= rd_q;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit: results, write-back, latency, start
// ignored while busy, and reset abort. Expected values queue in a scoreboard.
module tb_muldiv_unit;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [63:0] rs1_data, rs2_data;
  logic [5:0]  rd_addr;
  logic        busy, done, write_en;
  logic [63:0] result;
  logic [5:0]  wr_addr;

  muldiv_unit #(.XLEN(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result),
    .wr_addr(wr_addr), .write_en(write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [5:0]  wa;
    logic        we;
    int          edges;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   done_count = 0;
  int   we_count   = 0;

  always @(negedge clk) begin
    if (done)     done_count++;
    if (write_en) we_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference built on wide native arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a,
                                            input logic [63:0] b);
    logic signed [127:0] sa, sb2, ub;
    logic [127:0] p;
    sa  = {{64{a[63]}}, a};
    sb2 = {{64{b[63]}}, b};
    ub  = {64'b0, b};
    case (o)
      3'd0: begin p = sa * sb2; return p[63:0]; end
      3'd1: begin p = sa * sb2; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      3'd4: begin
        if (b == 64'd0) return ONES;
        if (a == SMIN && b == ONES) return SMIN;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 64'd0) ? ONES : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == SMIN && b == ONES) return 64'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  // Edges counted after the acceptance edge until done is seen: XLEN normally, 0 on the fast path.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] rd,
                        input logic [63:0] exp_res, input int exp_edges, input int pulse_at);
    exp_t e, got;
    int   edges;
    e.tag = tag; e.res = exp_res; e.wa = rd; e.we = (rd != 6'd0); e.edges = exp_edges;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
    rd_addr = 6'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      start = (edges == pulse_at);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    got = sb.pop_front();
    check({got.tag, "_edges"}, 64'(edges), 64'(got.edges));
    check({got.tag, "_result"}, result, got.res);
    check({got.tag, "_wr_addr"}, 64'(wr_addr), 64'(got.wa));
    check({got.tag, "_write_en"}, 64'(write_en), 64'(got.we));
    @(posedge clk); #1;
    check({got.tag, "_done_low"}, 64'({done, write_en, busy}), 64'd0);
  endtask

  initial begin
    int          dc0, wc0;
    logic [2:0]  ro;
    logic [63:0] ra, rb;
    logic [5:0]  rrd;
    bit          rfast;

    rst = 1'b1; start = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(write_en), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    rst = 1'b0;

    run_op("mul_7_m3", 3'd0, 64'd7, -64'd3, 6'd5, 64'hFFFF_FFFF_FFFF_FFEB, 64, -1);
    run_op("mulhu_ones", 3'd3, ONES, ONES, 6'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64, -1);
    run_op("mulh_ones", 3'd1, ONES, ONES, 6'd7, 64'd0, 64, -1);
    run_op("mulhsu_ones", 3'd2, ONES, ONES, 6'd8, ONES, 64, -1);
    run_op("mul_zero", 3'd0, 64'd0, 64'd99, 6'd9, 64'd0, 64, -1);
    run_op("div_m7_2", 3'd4, -64'd7, 64'd2, 6'd10, -64'd3, 64, -1);
    run_op("rem_m7_2", 3'd6, -64'd7, 64'd2, 6'd11, -64'd1, 64, -1);
    run_op("remu_100_7", 3'd7, 64'd100, 64'd7, 6'd13, 64'd2, 64, -1);
    run_op("divu_100_7", 3'd5, 64'd100, 64'd7, 6'd12, 64'd14, 64, -1);
    repeat (5) @(posedge clk);
    #1;
    check("hold_result", result, 64'd14);
    check("hold_wr_addr", 64'(wr_addr), 64'd12);

    run_op("divu_5_0", 3'd5, 64'd5, 64'd0, 6'd14, ONES, 0, -1);
    run_op("rem_5_0", 3'd6, 64'd5, 64'd0, 6'd15, 64'd5, 0, -1);
    run_op("div_ovf", 3'd4, SMIN, ONES, 6'd16, SMIN, 0, -1);
    run_op("rem_ovf", 3'd6, SMIN, ONES, 6'd17, 64'd0, 0, -1);

    dc0 = done_count;
    run_op("mul_x0", 3'd0, 64'd3, 64'd4, 6'd0, 64'd12, 64, 10);
    repeat (80) @(negedge clk);
    check("x0_single_done", 64'(done_count - dc0), 64'd1);
    check("x0_idle", 64'(busy), 64'd0);

    dc0 = done_count;
    wc0 = we_count;
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_data = 64'd123; rs2_data = 64'd456; rd_addr = 6'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_outputs", {busy, done, write_en, wr_addr, result[56:0]}, 64'd0);
    check("abort_result_hi", 64'(result[63:57]), 64'd0);
    repeat (80) @(negedge clk);
    check("abort_no_done", 64'(done_count - dc0), 64'd0);
    check("abort_no_we", 64'(we_count - wc0), 64'd0);
    run_op("after_abort", 3'd0, 64'd123, 64'd456, 6'd9, 64'd56088, 64, -1);

    for (int i = 0; i < 8; i++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      if (i == 5) rb = 64'd0;
      rrd = 6'($urandom_range(1, 63));
      rfast = ro[2] && (rb == 64'd0 || (!ro[0] && ra == SMIN && rb == ONES));
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rrd, ref_model(ro, ra, rb),
             rfast ? 0 : 64, -1);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
